// File: rtl/dtype_pipe_pkg.sv
// Shared constants and helpers for the dtype_pipe register pipeline.
// Exports the default width/depth and the occupancy-counter width function.
package dtype_pkg;

  localparam int DTYPE_WIDTH_DEF = 8;
  localparam int DTYPE_DEPTH_DEF = 4;

  // Bits needed to count 0..depth inclusive.
  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/dtype_pipe_stage.sv
// One pipeline stage: a WIDTH-bit data register and a valid flop sharing en/clr.
// Data and valid are loaded together but never gate one another.
module dtype_stage #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  input  logic             d_vld,
  output logic [WIDTH-1:0] q,
  output logic             q_vld
);

  logic [WIDTH-1:0] data_d, data_q;
  logic             vld_d, vld_q;

  // Flush outranks the shift enable; with neither, the stage holds.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (clr) begin
      data_d = RST_VAL;
      vld_d  = 1'b0;
    end else if (en) begin
      data_d = d;
      vld_d  = d_vld;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= RST_VAL;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q     = data_q;
  assign q_vld = vld_q;

endmodule

// File: rtl/dtype_pipe.sv
// WIDTH-bit, DEPTH-stage enabled delay line with per-stage valid, flush and reset value.
// Define DTYPE_PIPE_OCC_EN to add the registered occupancy counter and its occ port.
module dtype_pipe
  import dtype_pkg::*;
#(
  parameter int               WIDTH   = DTYPE_WIDTH_DEF,
  parameter int               DEPTH   = DTYPE_DEPTH_DEF,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      clr,
  input  logic [WIDTH-1:0]          d,
  input  logic                      d_vld,
  output logic [WIDTH-1:0]          q,
  output logic [WIDTH-1:0]          q_n,
`ifdef DTYPE_PIPE_OCC_EN
  output logic [occ_w(DEPTH)-1:0]   occ,
`endif
  output logic                      q_vld
);

  logic [WIDTH-1:0] data_w [DEPTH];
  logic [DEPTH-1:0] vld_w;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] stage_d;
      logic             stage_d_vld;

      if (gi == 0) begin : g_head
        assign stage_d     = d;
        assign stage_d_vld = d_vld;
      end else begin : g_body
        assign stage_d     = data_w[gi-1];
        assign stage_d_vld = vld_w[gi-1];
      end

      dtype_stage #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_stage (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .clr   (clr),
        .d     (stage_d),
        .d_vld (stage_d_vld),
        .q     (data_w[gi]),
        .q_vld (vld_w[gi])
      );
    end
  endgenerate

  assign q     = data_w[DEPTH-1];
  assign q_n   = ~data_w[DEPTH-1];
  assign q_vld = vld_w[DEPTH-1];

`ifdef DTYPE_PIPE_OCC_EN
  localparam int OW = occ_w(DEPTH);

  logic [OW-1:0] occ_d, occ_q;

  // Tracks the stage shift exactly: one word enters with d_vld, one leaves from the tail.
  always_comb begin
    occ_d = occ_q;
    if (clr) begin
      occ_d = '0;
    end else if (en) begin
      occ_d = occ_q + OW'(d_vld) - OW'(vld_w[DEPTH-1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;

  occ_matches_vld: assert property (@(posedge clk) disable iff (rst)
    occ_q == OW'($countones(vld_w)));
`endif

endmodule

// File: tb/tb_dtype_pipe.sv
// Directed self-checking bench for dtype_pipe (DEPTH=4, RST_VAL=A5) plus a DEPTH=1 instance.
// Occupancy checks run only when DTYPE_PIPE_OCC_EN is defined.
module tb_dtype_pipe;
  import dtype_pkg::*;

  logic       clk = 1'b0;
  logic       rst, en, clr, d_vld;
  logic [7:0] d;
  logic [7:0] q, q_n, q1, q1_n;
  logic       q_vld, q1_vld;
`ifdef DTYPE_PIPE_OCC_EN
  logic [occ_w(4)-1:0] occ;
  logic [occ_w(1)-1:0] occ1;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dtype_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .d_vld(d_vld),
    .q(q), .q_n(q_n),
`ifdef DTYPE_PIPE_OCC_EN
    .occ(occ),
`endif
    .q_vld(q_vld)
  );

  dtype_pipe #(.WIDTH(8), .DEPTH(1), .RST_VAL(8'h3C)) dut1 (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d), .d_vld(d_vld),
    .q(q1), .q_n(q1_n),
`ifdef DTYPE_PIPE_OCC_EN
    .occ(occ1),
`endif
    .q_vld(q1_vld)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [7:0] eq, input logic ev);
    chk({tag, ".q"}, {24'd0, q}, {24'd0, eq});
    chk({tag, ".q_n"}, {24'd0, q_n}, {24'd0, ~eq});
    chk({tag, ".q_vld"}, {31'd0, q_vld}, {31'd0, ev});
    $display("%0t %s q=%02h q_n=%02h q_vld=%0b", $time, tag, q, q_n, q_vld);
  endtask

  task automatic chk_occ(input string tag, input int exp);
`ifdef DTYPE_PIPE_OCC_EN
    chk(tag, {29'd0, occ}, exp);
`endif
  endtask

  task automatic step(input logic e, input logic c, input logic [7:0] dd, input logic dv);
    en = e; clr = c; d = dd; d_vld = dv;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; d = 8'h00; d_vld = 1'b0;
    #3;
    chk_out("por", 8'hA5, 1'b0);
    chk("por.d1_q", {24'd0, q1}, 32'h3C);
    chk_occ("por.occ", 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Latency: 1..5, first word out after the 4th enabled edge.
    step(1, 0, 8'd1, 1); chk_out("lat.e1", 8'hA5, 0);
    chk("lat.d1_q", {24'd0, q1}, 32'd1); chk("lat.d1_vld", {31'd0, q1_vld}, 32'd1);
    chk("lat.d1_qn", {24'd0, q1_n}, 32'hFE);
    step(1, 0, 8'd2, 1); chk_out("lat.e2", 8'hA5, 0);
    step(1, 0, 8'd3, 1); chk_out("lat.e3", 8'hA5, 0);
    step(1, 0, 8'd4, 1); chk_out("lat.e4", 8'd1, 1);
    step(1, 0, 8'd5, 1); chk_out("lat.e5", 8'd2, 1);
    step(1, 0, 8'd0, 0); chk_out("lat.e6", 8'd3, 1);
    chk("lat.d1_idle_vld", {31'd0, q1_vld}, 32'd0);
    step(1, 0, 8'd0, 0); chk_out("lat.e7", 8'd4, 1);
    step(1, 0, 8'd0, 0); chk_out("lat.e8", 8'd5, 1);

    // Stall: two held cycles after word 2, one more while q shows 2.
    step(0, 1, 8'd0, 0); chk_out("stl.flush", 8'hA5, 0);
    chk("stl.d1_flush", {24'd0, q1}, 32'h3C);
    step(1, 0, 8'd1, 1); chk_out("stl.w1", 8'hA5, 0);
    step(1, 0, 8'd2, 1); chk_out("stl.w2", 8'hA5, 0);
    step(0, 0, 8'd9, 1); chk_out("stl.h1", 8'hA5, 0);
    chk("stl.d1_hold", {24'd0, q1}, 32'd2);
    step(0, 0, 8'd9, 1); chk_out("stl.h2", 8'hA5, 0);
    step(1, 0, 8'd3, 1); chk_out("stl.w3", 8'hA5, 0);
    step(1, 0, 8'd4, 1); chk_out("stl.w4", 8'd1, 1);
    step(1, 0, 8'd5, 1); chk_out("stl.w5", 8'd2, 1);
    step(0, 0, 8'd7, 1); chk_out("stl.h3", 8'd2, 1);
    step(1, 0, 8'd0, 0); chk_out("stl.o3", 8'd3, 1);
    step(1, 0, 8'd0, 0); chk_out("stl.o4", 8'd4, 1);
    step(1, 0, 8'd0, 0); chk_out("stl.o5", 8'd5, 1);
    step(1, 0, 8'd0, 0); chk_out("stl.o6", 8'd0, 0);

    // Flush wins over en; FF must never surface as valid.
    step(1, 0, 8'd7, 1);
    step(1, 0, 8'd8, 1);
    step(1, 0, 8'd9, 1); chk_out("fl.pre", 8'd0, 0);
    chk_occ("fl.pre.occ", 3);
    step(1, 1, 8'hFF, 1); chk_out("fl.edge", 8'hA5, 0);
    chk_occ("fl.edge.occ", 0);
    chk("fl.d1", {24'd0, q1}, 32'h3C); chk("fl.d1_vld", {31'd0, q1_vld}, 32'd0);
    step(1, 0, 8'd0, 0); chk_out("fl.i1", 8'hA5, 0);
    step(1, 0, 8'd0, 0); chk_out("fl.i2", 8'hA5, 0);
    step(1, 0, 8'd0, 0); chk_out("fl.i3", 8'hA5, 0);
    step(1, 0, 8'd0, 0); chk_out("fl.i4", 8'd0, 0);

    // Valid bubbles: data 11..14 with d_vld 1,0,1,1.
    step(1, 0, 8'd11, 1);
    step(1, 0, 8'd12, 0);
    step(1, 0, 8'd13, 1);
    step(1, 0, 8'd14, 1); chk_out("bub.1", 8'd11, 1);
    step(1, 0, 8'd0, 0);  chk_out("bub.2", 8'd12, 0);
    step(1, 0, 8'd0, 0);  chk_out("bub.3", 8'd13, 1);
    step(1, 0, 8'd0, 0);  chk_out("bub.4", 8'd14, 1);
    step(1, 0, 8'd0, 0);  chk_out("bub.5", 8'd0, 0);

    // Occupancy fill and drain.
    step(0, 1, 8'd0, 0);
    step(1, 0, 8'd21, 1); chk_occ("occ.f1", 1);
    step(1, 0, 8'd22, 1); chk_occ("occ.f2", 2);
    step(1, 0, 8'd23, 1); chk_occ("occ.f3", 3);
    step(1, 0, 8'd24, 1); chk_occ("occ.f4", 4); chk_out("occ.q21", 8'd21, 1);
    step(0, 0, 8'd0, 0);  chk_occ("occ.hold", 4);
    step(1, 0, 8'd0, 0);  chk_occ("occ.d1", 3); chk_out("occ.q22", 8'd22, 1);
    step(1, 0, 8'd0, 0);  chk_occ("occ.d2", 2);
    step(1, 0, 8'd0, 0);  chk_occ("occ.d3", 1);
    step(1, 0, 8'd0, 0);  chk_occ("occ.d4", 0); chk_out("occ.empty", 8'd0, 0);

    // Asynchronous reset mid-stream, then a normal first edge.
    step(1, 0, 8'd31, 1);
    step(1, 0, 8'd32, 1);
    step(1, 0, 8'd33, 1);
    step(1, 0, 8'd34, 1); chk_out("ar.pre", 8'd31, 1);
    #2 rst = 1'b1;
    #1 chk_out("ar.now", 8'hA5, 0);
    chk("ar.d1", {24'd0, q1}, 32'h3C);
    chk("ar.d1_qn", {24'd0, q1_n}, 32'hC3);
    chk_occ("ar.occ", 0);
    @(negedge clk);
    rst = 1'b0;
    step(1, 0, 8'd41, 1); chk_out("ar.e1", 8'hA5, 0);
    chk("ar.d1_e1", {24'd0, q1}, 32'd41);
    chk_occ("ar.e1.occ", 1);
    step(1, 0, 8'd42, 1);
    step(1, 0, 8'd43, 1);
    step(1, 0, 8'd44, 1); chk_out("ar.e4", 8'd41, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
